// File: rtl/muldiv_sequencer.sv
// Iterative 32x32 multiply / 32/32 divide unit with HI/LO result registers.
// One shift-add or restoring shift-subtract step per cycle; the sign fix-up happens in FIX.
module muldiv_sequencer (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  input  logic        mthi_i,
  input  logic        mtlo_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t      r_state, w_next;
  logic [4:0]  r_cnt;
  logic [31:0] r_a, r_b;
  logic [63:0] r_acc;
  logic        r_div, r_qneg, r_rneg, r_dz;
  logic        r_busy, r_done;
  logic [31:0] r_hi, r_lo;

  logic        w_sgn, w_rs_neg, w_rt_neg;
  logic [31:0] w_rs_mag, w_rt_mag;
  logic [32:0] w_madd;
  logic [63:0] w_mstep;
  logic [32:0] w_dtop;
  logic [33:0] w_ddiff;
  logic        w_dok;
  logic [63:0] w_dstep;
  logic [63:0] w_prod;
  logic [31:0] w_quo, w_rem;

  assign w_sgn    = ~op_i[0];
  assign w_rs_neg = w_sgn & rs_i[31];
  assign w_rt_neg = w_sgn & rt_i[31];
  assign w_rs_mag = w_rs_neg ? -rs_i : rs_i;
  assign w_rt_mag = w_rt_neg ? -rt_i : rt_i;

  // Multiply: acc = {partial, multiplier}; add multiplicand on LSB, shift right.
  assign w_madd  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_a} : 33'd0);
  assign w_mstep = {w_madd, r_acc[31:1]};

  // Divide: acc = {remainder, dividend/quotient}; shift left, trial subtract.
  assign w_dtop  = r_acc[63:31];
  assign w_ddiff = {1'b0, w_dtop} - {2'b00, r_b};
  assign w_dok   = ~w_ddiff[33];
  assign w_dstep = {w_dok ? w_ddiff[31:0] : w_dtop[31:0],
                    r_acc[30:0], w_dok};

  assign w_prod = r_qneg ? -r_acc : r_acc;
  assign w_quo  = r_qneg ? -r_acc[31:0] : r_acc[31:0];
  assign w_rem  = r_rneg ? -r_acc[63:32] : r_acc[63:32];

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start_i) w_next = op_i[1] ? DIV : MUL;
      MUL,
      DIV:     if (r_cnt == 5'd31) w_next = FIX;
      FIX:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_i) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_cnt  <= 5'd0;
      r_a    <= 32'd0;
      r_b    <= 32'd0;
      r_acc  <= 64'd0;
      r_div  <= 1'b0;
      r_qneg <= 1'b0;
      r_rneg <= 1'b0;
      r_dz   <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_hi   <= 32'd0;
      r_lo   <= 32'd0;
    end else begin
      r_busy <= (w_next != IDLE);
      r_done <= (r_state == FIX);
      unique case (r_state)
        IDLE: begin
          if (start_i) begin
            r_cnt  <= 5'd0;
            r_a    <= w_rs_mag;
            r_b    <= w_rt_mag;
            r_acc  <= {32'd0, op_i[1] ? w_rs_mag : w_rt_mag};
            r_div  <= op_i[1];
            r_qneg <= w_rs_neg ^ w_rt_neg;
            r_rneg <= w_rs_neg;
            r_dz   <= (rt_i == 32'd0);
          end else begin
            if (mthi_i) r_hi <= rs_i;
            if (mtlo_i) r_lo <= rs_i;
          end
        end
        MUL: begin
          r_acc <= w_mstep;
          r_cnt <= r_cnt + 5'd1;
        end
        DIV: begin
          r_acc <= w_dstep;
          r_cnt <= r_cnt + 5'd1;
        end
        FIX: begin
          if (!r_div) begin
            r_hi <= w_prod[63:32];
            r_lo <= w_prod[31:0];
          end else if (r_dz) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
          end else begin
            r_hi <= w_rem;
            r_lo <= w_quo;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o = r_busy;
  assign done_o = r_done;
  assign hi_o   = r_hi;
  assign lo_o   = r_lo;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: arithmetic reference model checked every cycle,
// plus hand-computed result literals for the directed vectors.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset_i, start_i, mthi_i, mtlo_i;
  logic [1:0]  op_i;
  logic [31:0] rs_i, rt_i;
  logic        busy_o, done_o;
  logic [31:0] hi_o, lo_o;

  muldiv_sequencer dut (
    .clk     (clk),
    .reset_i (reset_i),
    .start_i (start_i),
    .op_i    (op_i),
    .rs_i    (rs_i),
    .rt_i    (rt_i),
    .mthi_i  (mthi_i),
    .mtlo_i  (mtlo_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .hi_o    (hi_o),
    .lo_o    (lo_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Result as {HI, LO} from plain integer arithmetic
  function automatic logic [63:0] ref_res(input logic [1:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, p;
    longint unsigned ma, mb, q, r;
    logic [31:0] qq, rr;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    res = 64'd0;
    case (op)
      2'd0: begin
        p = sa * sb;
        res = p;
      end
      2'd1: res = {32'd0, a} * {32'd0, b};
      2'd2: begin
        if (b != 0) begin
          ma = (sa < 0) ? -sa : sa;
          mb = (sb < 0) ? -sb : sb;
          q = ma / mb;
          r = ma % mb;
          qq = q[31:0];
          rr = r[31:0];
          if ((sa < 0) != (sb < 0)) qq = -qq;
          if (sa < 0) rr = -rr;
          res = {rr, qq};
        end
      end
      default: if (b != 0) res = {a % b, a / b};
    endcase
    return res;
  endfunction

  int          m_rem  = 0;
  logic        m_done = 1'b0;
  logic [31:0] m_hi   = 32'd0;
  logic [31:0] m_lo   = 32'd0;
  logic [63:0] m_pend = 64'd0;

  always @(posedge clk) begin
    if (reset_i) begin
      m_rem  <= 0;
      m_done <= 1'b0;
      m_hi   <= 32'd0;
      m_lo   <= 32'd0;
    end else if (m_rem > 0) begin
      m_rem  <= m_rem - 1;
      m_done <= (m_rem == 1);
      if (m_rem == 1) begin
        m_hi <= m_pend[63:32];
        m_lo <= m_pend[31:0];
      end
    end else begin
      m_done <= 1'b0;
      if (start_i) begin
        m_pend <= ref_res(op_i, rs_i, rt_i);
        m_rem  <= 33;
      end else begin
        if (mthi_i) m_hi <= rs_i;
        if (mtlo_i) m_lo <= rs_i;
      end
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("m_busy", 32'(busy_o), 32'(m_rem > 0));
      chk("m_done", 32'(done_o), 32'(m_done));
      chk("m_hi", hi_o, m_hi);
      chk("m_lo", lo_o, m_lo);
    end
  end

  task automatic wait_done(output int nb);
    bit ok;
    nb = 0;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (done_o) ok = 1'b1;
      else begin
        if (busy_o) nb++;
        @(negedge clk);
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL done_timeout: got none want done within 40");
    end
  endtask

  task automatic run(input logic [1:0] op, input logic [31:0] a,
                     input logic [31:0] b, output int nb);
    start_i = 1'b1;
    op_i = op;
    rs_i = a;
    rt_i = b;
    @(negedge clk);
    start_i = 1'b0;
    rs_i = $urandom;
    rt_i = $urandom;
    wait_done(nb);
  endtask

  int nb, t1, t2;
  bit seen;

  initial begin
    reset_i = 1'b1;
    start_i = 1'b0;
    mthi_i  = 1'b0;
    mtlo_i  = 1'b0;
    op_i    = 2'd0;
    rs_i    = 32'd0;
    rt_i    = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_hi", hi_o, 32'd0);
    chk("rst_lo", lo_o, 32'd0);
    reset_i = 1'b0;
    @(negedge clk);

    run(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, nb);
    chk("multu_busy_len", nb, 33);
    chk("multu_busy_at_done", 32'(busy_o), 32'd0);
    chk("multu_hi", hi_o, 32'hFFFFFFFE);
    chk("multu_lo", lo_o, 32'h00000001);

    run(2'd0, 32'hFFFFFFFE, 32'h00000003, nb);
    chk("mult_neg_hi", hi_o, 32'hFFFFFFFF);
    chk("mult_neg_lo", lo_o, 32'hFFFFFFFA);

    run(2'd0, 32'h80000000, 32'h80000000, nb);
    chk("mult_min_hi", hi_o, 32'h40000000);
    chk("mult_min_lo", lo_o, 32'h00000000);

    run(2'd2, 32'hFFFFFFF9, 32'h00000002, nb);
    chk("div_neg_hi", hi_o, 32'hFFFFFFFF);
    chk("div_neg_lo", lo_o, 32'hFFFFFFFD);

    run(2'd3, 32'd7, 32'd0, nb);
    chk("divu_zero_len", nb, 33);
    chk("divu_zero_hi", hi_o, 32'd0);
    chk("divu_zero_lo", lo_o, 32'd0);

    run(2'd2, 32'h80000000, 32'hFFFFFFFF, nb);
    chk("div_ovf_hi", hi_o, 32'd0);
    chk("div_ovf_lo", lo_o, 32'h80000000);

    run(2'd3, 32'd100, 32'd7, nb);
    chk("divu_hi", hi_o, 32'd2);
    chk("divu_lo", lo_o, 32'd14);

    // Moves and a restart while busy must be ignored
    start_i = 1'b1;
    op_i = 2'd1;
    rs_i = 32'h00010000;
    rt_i = 32'h00030000;
    @(negedge clk);
    start_i = 1'b0;
    repeat (5) @(negedge clk);
    mthi_i = 1'b1;
    start_i = 1'b1;
    op_i = 2'd0;
    rs_i = 32'h12345678;
    rt_i = 32'd5;
    @(negedge clk);
    mthi_i = 1'b0;
    start_i = 1'b0;
    wait_done(nb);
    chk("busy_mv_hi", hi_o, 32'h00000003);
    chk("busy_mv_lo", lo_o, 32'h00000000);
    mtlo_i = 1'b1;
    rs_i = 32'hAAAA5555;
    @(negedge clk);
    mtlo_i = 1'b0;
    chk("mtlo_hi", hi_o, 32'h00000003);
    chk("mtlo_lo", lo_o, 32'hAAAA5555);

    mthi_i = 1'b1;
    mtlo_i = 1'b1;
    rs_i = 32'h0F0F0F0F;
    @(negedge clk);
    chk("mvboth_hi", hi_o, 32'h0F0F0F0F);
    chk("mvboth_lo", lo_o, 32'h0F0F0F0F);

    start_i = 1'b1;
    op_i = 2'd1;
    rs_i = 32'd2;
    rt_i = 32'd3;
    @(negedge clk);
    start_i = 1'b0;
    mthi_i = 1'b0;
    mtlo_i = 1'b0;
    chk("startwin_hi_hold", hi_o, 32'h0F0F0F0F);
    wait_done(nb);
    chk("startwin_hi", hi_o, 32'd0);
    chk("startwin_lo", lo_o, 32'd6);

    // Abort a divide at busy cycle 10
    start_i = 1'b1;
    op_i = 2'd2;
    rs_i = 32'd100;
    rt_i = 32'd3;
    @(negedge clk);
    start_i = 1'b0;
    repeat (9) @(negedge clk);
    chk("abort_busy_before", 32'(busy_o), 32'd1);
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    chk("abort_busy", 32'(busy_o), 32'd0);
    chk("abort_hi", hi_o, 32'd0);
    chk("abort_lo", lo_o, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_o) seen = 1'b1;
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    run(2'd3, 32'd9, 32'd2, nb);
    chk("after_abort_hi", hi_o, 32'd1);
    chk("after_abort_lo", lo_o, 32'd4);

    // Back-to-back with start held high
    start_i = 1'b1;
    op_i = 2'd1;
    rs_i = 32'd6;
    rt_i = 32'd7;
    @(negedge clk);
    wait_done(nb);
    t1 = cyc;
    chk("b2b_a_hi", hi_o, 32'd0);
    chk("b2b_a_lo", lo_o, 32'd42);
    rs_i = 32'h00010001;
    rt_i = 32'h00010001;
    @(negedge clk);
    start_i = 1'b0;
    wait_done(nb);
    t2 = cyc;
    chk("b2b_gap", t2 - t1, 34);
    chk("b2b_b_hi", hi_o, 32'h00000001);
    chk("b2b_b_lo", lo_o, 32'h00020001);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
